// File: rtl/csa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csa_pkg
//  Description : Shared definitions for the carry-save accumulator pipeline:
//                FSM state encoding and compile-time helpers for sizing the
//                3:2 compressor tree.
//  Revision    : 1.0 - initial release
// ============================================================================
package csa_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ACCUM   = 2'd1;
    localparam logic [1:0] c_ST_RESOLVE = 2'd2;
    localparam logic [1:0] c_ST_OUT     = 2'd3;

    // Number of vectors still alive after 'level' layers of 3:2 compression.
    // Each layer turns every full group of three vectors into two; leftovers
    // pass straight through.
    function automatic int csa_level_count(input int n_vec, input int level);
        int n;
        n = n_vec;
        for (int i = 0; i < level; i++) begin
            n = n - (n / 3);
        end
        return n;
    endfunction

    // Number of compressor layers needed to reduce n_vec vectors to two.
    function automatic int csa_tree_levels(input int n_vec);
        int n;
        int lv;
        n  = n_vec;
        lv = 0;
        while (n > 2) begin
            n  = n - (n / 3);
            lv = lv + 1;
        end
        return lv;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_3to2.sv
`default_nettype none
// ============================================================================
//  Module      : csa_3to2
//  Description : Bitwise 3:2 carry-save compressor (row of full adders).
//                s = x ^ y ^ z, c = maj(x, y, z). The carry vector is NOT
//                shifted here; the caller applies the weight-2 shift.
//  Ports       : i_x, i_y, i_z  - input vectors (W bits)
//                o_s            - sum vector
//                o_c            - unshifted carry vector
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_3to2 #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic [W-1:0] i_z,
    output logic [W-1:0] o_s,
    output logic [W-1:0] o_c
);

    assign o_s = i_x ^ i_y ^ i_z;
    assign o_c = (i_x & i_y) | (i_x & i_z) | (i_y & i_z);

endmodule
`default_nettype wire

// File: rtl/csa_accum_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : csa_accum_pipe
//  Description : Streaming multi-operand carry-save accumulator. Each accepted
//                beat of NUM_OPS operands is folded into a stored sum/carry
//                pair through a single-cycle 3:2 compressor tree; one
//                carry-propagate add resolves the pair after the last beat and
//                the result is held on a valid/ready output.
//  Ports       : clk, rst (sync, active-high)
//                in_valid/in_ready/in_ops/in_last   - beat input
//                out_valid/out_ready/out_sum/out_beats - result output
//  Config      : CSA_ACC_SIGNED_EN - operands sign-extended (two's complement)
//                instead of zero-extended.
//  Revision    : 1.0 - initial release
// ============================================================================
module csa_accum_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_OPS   = 4,
    parameter int ACC_WIDTH = WIDTH + 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_ops,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     out_sum,
    output logic [CNT_WIDTH-1:0]     out_beats
);

    // Operands plus the stored sum and carry vectors feed the tree.
    localparam int c_NV     = NUM_OPS + 2;
    localparam int c_LEVELS = csa_tree_levels(c_NV);

    logic [1:0]           r_state;
    logic [ACC_WIDTH-1:0] r_sum;
    logic [ACC_WIDTH-1:0] r_carry;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_out_sum;
    logic [CNT_WIDTH-1:0] r_out_beats;

    // w_tree[l][i] : vector i entering compressor layer l
    logic [ACC_WIDTH-1:0] w_tree [0:c_LEVELS][0:c_NV-1];

    // ---------------- Layer 0: extended operands + stored pair -------------
    for (genvar k = 0; k < NUM_OPS; k++) begin : g_ext
`ifdef CSA_ACC_SIGNED_EN
        assign w_tree[0][k] = {{(ACC_WIDTH-WIDTH){in_ops[k*WIDTH+WIDTH-1]}},
                               in_ops[k*WIDTH +: WIDTH]};
`else
        assign w_tree[0][k] = {{(ACC_WIDTH-WIDTH){1'b0}}, in_ops[k*WIDTH +: WIDTH]};
`endif
    end
    assign w_tree[0][NUM_OPS]   = r_sum;
    assign w_tree[0][NUM_OPS+1] = r_carry;

    // ---------------- Compressor layers ------------------------------------
    for (genvar l = 0; l < c_LEVELS; l++) begin : g_lvl
        localparam int c_N  = csa_level_count(c_NV, l);
        localparam int c_G  = c_N / 3;
        localparam int c_NN = c_N - c_G;

        for (genvar g = 0; g < c_G; g++) begin : g_node
            logic [ACC_WIDTH-1:0] w_s;
            logic [ACC_WIDTH-1:0] w_c;
            csa_3to2 #(.W(ACC_WIDTH)) u_csa (
                .i_x (w_tree[l][3*g]),
                .i_y (w_tree[l][3*g+1]),
                .i_z (w_tree[l][3*g+2]),
                .o_s (w_s),
                .o_c (w_c)
            );
            assign w_tree[l+1][2*g]   = w_s;
            // Carry has weight 2; the bit shifted out of the top is dropped,
            // which gives the modulo-2^ACC_WIDTH wrap.
            assign w_tree[l+1][2*g+1] = {w_c[ACC_WIDTH-2:0], 1'b0};
        end

        for (genvar r = 0; r < c_N - 3*c_G; r++) begin : g_pass
            assign w_tree[l+1][2*c_G + r] = w_tree[l][3*c_G + r];
        end

        for (genvar z = c_NN; z < c_NV; z++) begin : g_zero
            assign w_tree[l+1][z] = '0;
        end
    end

    // ---------------- Control ----------------------------------------------
    assign in_ready  = (r_state == c_ST_IDLE) || (r_state == c_ST_ACCUM);
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_beats = r_out_beats;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_sum       <= '0;
            r_carry     <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_beats <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_ACCUM: begin
                    if (in_valid) begin
                        r_sum   <= w_tree[c_LEVELS][0];
                        r_carry <= w_tree[c_LEVELS][1];
                        if (r_count != {CNT_WIDTH{1'b1}}) begin
                            r_count <= r_count + 1'b1;
                        end
                        r_state <= in_last ? c_ST_RESOLVE : c_ST_ACCUM;
                    end
                end
                c_ST_RESOLVE: begin
                    r_out_sum   <= r_sum + r_carry;
                    r_out_beats <= r_count;
                    r_out_valid <= 1'b1;
                    r_state     <= c_ST_OUT;
                end
                c_ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_sum       <= '0;
                        r_carry     <= '0;
                        r_count     <= '0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csa_accum_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csa_accum_pipe
//  Description : Self-checking bench for csa_accum_pipe (WIDTH=8, NUM_OPS=4,
//                ACC_WIDTH=16, CNT_WIDTH=16). Reference is a plain integer
//                running total and beat tally.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_accum_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ops;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [15:0] out_beats;

    int checks = 0;
    int errors = 0;
    int m_sum  = 0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    csa_accum_pipe #(
        .WIDTH     (8),
        .NUM_OPS   (4),
        .ACC_WIDTH (16),
        .CNT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ops    (in_ops),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_beats (out_beats)
    );

    function automatic int ext8(input logic [7:0] v);
`ifdef CSA_ACC_SIGNED_EN
        return int'($signed(v));
`else
        return int'(v);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one beat until accepted, then fold it into the reference.
    task automatic send_beat(input logic [31:0] ops, input logic last);
        int n;
        in_valid = 1'b1;
        in_ops   = ops;
        in_last  = last;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        step();
        for (int k = 0; k < 4; k++) m_sum += ext8(ops[k*8 +: 8]);
        if (m_cnt < 65535) m_cnt++;
        in_valid = 1'b0;
        in_ops   = $urandom;
        in_last  = 1'($urandom);
    endtask

    // Wait for the result, compare with the reference, apply 'hold' cycles
    // of backpressure, then complete the handshake.
    task automatic get_result(input string tag, input int hold);
        int n;
        logic [15:0] s0;
        logic [15:0] b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"},   {16'd0, out_sum},   {16'd0, m_sum[15:0]});
        check({tag, "_beats"}, {16'd0, out_beats}, {16'd0, m_cnt[15:0]});
        s0 = 16'(m_sum);
        b0 = 16'(m_cnt);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_sum"},   {16'd0, out_sum},   {16'd0, s0});
            check({tag, "_hold_beats"}, {16'd0, out_beats}, {16'd0, b0});
            check({tag, "_hold_ready"}, {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        step();
        check({tag, "_done_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_done_ready"}, {31'd0, in_ready},  32'd1);
        out_ready = 1'b0;
        m_sum = 0;
        m_cnt = 0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ops    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum",   {16'd0, out_sum},   32'd0);
        check("rst_out_beats", {16'd0, out_beats}, 32'd0);
        rst = 1'b0;
        step();

        // 1. single beat {1,2,3,4}, consumer always ready, exact latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ops    = 32'h04030201;
        in_last   = 1'b1;
        step();
        in_valid = 1'b0;
        check("t1_resolve_valid", {31'd0, out_valid}, 32'd0);
        check("t1_resolve_ready", {31'd0, in_ready},  32'd0);
        step();
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_sum",   {16'd0, out_sum},   32'd10);
        check("t1_beats", {16'd0, out_beats}, 32'd1);
        step();
        check("t1_done_valid", {31'd0, out_valid}, 32'd0);
        check("t1_done_ready", {31'd0, in_ready},  32'd1);
        out_ready = 1'b0;

        // 2. three beats of all-FF
        for (int i = 0; i < 3; i++) send_beat(32'hFFFFFFFF, i == 2);
        get_result("t2", 0);

        // 3. 65 beats of all-FF wraps the 16-bit sum
        for (int i = 0; i < 65; i++) send_beat(32'hFFFFFFFF, i == 64);
        get_result("t3", 0);

        // 4. backpressure for 5 cycles, then a fresh group starts from zero
        send_beat($urandom, 1'b0);
        send_beat($urandom, 1'b1);
        get_result("t4", 5);
        send_beat(32'h04030201, 1'b1);
        get_result("t4_next", 0);

        // 5. reset mid-group discards the partial sum
        send_beat(32'h01010101, 1'b0);
        send_beat(32'h01010101, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_sum = 0;
        m_cnt = 0;
        check("t5_rst_ready", {31'd0, in_ready},  32'd1);
        check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_beats", {16'd0, out_beats}, 32'd0);
        send_beat(32'h00000002, 1'b1);
        get_result("t5", 0);

        // 6. operands {FF,FF,01,00}: result depends on extension mode
        send_beat(32'h0001FFFF, 1'b1);
        step();
`ifdef CSA_ACC_SIGNED_EN
        check("t6_sum_const", {16'd0, out_sum}, 32'h0000FFFF);
`else
        check("t6_sum_const", {16'd0, out_sum}, 32'h000001FF);
`endif
        get_result("t6", 0);

        // Random groups with input gaps (garbage while invalid) and random
        // output backpressure.
        for (int g = 0; g < 25; g++) begin
            int nb;
            nb = int'($urandom_range(1, 8));
            for (int b = 0; b < nb; b++) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                for (int q = 0; q < gap; q++) begin
                    in_valid = 1'b0;
                    in_ops   = $urandom;
                    in_last  = 1'($urandom);
                    step();
                end
                send_beat($urandom, b == nb - 1);
            end
            get_result("rnd", int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
